// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback vs. queued MDU results,
// plus the busy-register scoreboard that drives the decode hazard stall.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_reg,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      mdu_valid,
  input  logic [REG_AW-1:0]         mdu_reg,
  input  logic [DATA_W-1:0]         mdu_data,
  output logic                      mdu_ready,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_reg,
  input  logic [REG_AW-1:0]         rs1,
  input  logic [REG_AW-1:0]         rs2,
  output logic                      stall,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int NREG = 1 << REG_AW;
  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = PW + 1;

  logic [REG_AW-1:0] q_reg  [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     wptr;
  logic [CW-1:0]     cnt;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_n;
  logic              push;
  logic              pop;
  logic [REG_AW-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  assign q_count   = cnt;
  assign mdu_ready = (cnt != CW'(QDEPTH));
  assign push      = mdu_valid & mdu_ready;
  assign pop       = ~wb_valid & (cnt != '0);
  assign head_reg  = q_reg[rptr];
  assign head_data = q_data[rptr];

  // Hazard: RAW on either source, or WAW on a new long-latency issue.
  assign stall = ((rs1 != '0) & busy[rs1])
               | ((rs2 != '0) & busy[rs2])
               | (issue_valid & (issue_reg != '0) & busy[issue_reg]);

  // FIFO storage; contents are only meaningful under the count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wptr]  <= mdu_reg;
      q_data[wptr] <= mdu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Scoreboard next state: a retiring MDU write clears, a new issue sets (set wins).
  always_comb begin
    busy_n = busy;
    if (pop) busy_n[head_reg] = 1'b0;
    if (issue_valid && (issue_reg != '0)) busy_n[issue_reg] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_n;
  end

  // Registered write port: pipeline first, then FIFO head; x0 writes suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_valid) begin
      rf_we    <= (wb_reg != '0);
      rf_waddr <= wb_reg;
      rf_wdata <= wb_data;
    end else if (pop) begin
      rf_we    <= (head_reg != '0);
      rf_waddr <= head_reg;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  q_count;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DATA_W(32), .REG_AW(5), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
    issue_valid = 0; issue_reg = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    total++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      bad++;
      $display("FAIL rst_port got we=%b a=%0d d=%h want 0/0/0",
               rf_we, rf_waddr, rf_wdata);
    end
    cyc(); cyc();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (rf_we !== 1'b0 || q_count !== 2'd0 || mdu_ready !== 1'b1 || stall !== 1'b0) begin
        bad++;
        $display("FAIL rst_idle[%0d] got we=%b q=%0d rdy=%b st=%b want 0/0/1/0",
                 i, rf_we, q_count, mdu_ready, stall);
      end
    end
  endtask

  task automatic test_wb();
    idle();
    wb_valid = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
    cyc();
    idle();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wb_write got we=%b a=%0d d=%h want 1/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    cyc();
    total++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wb_hold got we=%b a=%0d d=%h want 0/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    wb_valid = 1; wb_reg = 0; wb_data = 32'h1111;
    cyc();
    idle();
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("FAIL wb_x0 got we=%b want 0", rf_we);
    end
  endtask

  task automatic test_mdu_hazard();
    idle();
    issue_valid = 1; issue_reg = 7;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL haz_issue got stall=%b want 0", stall);
    end
    cyc();
    issue_valid = 0; rs1 = 7;
    mdu_valid = 1; mdu_reg = 7; mdu_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_reg = 5'(3 + i); wb_data = 32'(100 + i);
      #1;
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL haz_stall[%0d] got stall=%b want 1", i, stall);
      end
      cyc();
      mdu_valid = 0;
      total++;
      if (q_count !== 2'd1 || rf_we !== 1'b1 || rf_waddr !== 5'(3 + i)) begin
        bad++;
        $display("FAIL haz_wb[%0d] got q=%0d we=%b a=%0d want 1/1/%0d",
                 i, q_count, rf_we, rf_waddr, 3 + i);
      end
    end
    wb_valid = 0;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL haz_stall_pop got stall=%b want 1", stall);
    end
    cyc();
    #1;
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234 ||
        q_count !== 2'd0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL haz_drain got we=%b a=%0d d=%h q=%0d st=%b want 1/7/1234/0/0",
               rf_we, rf_waddr, rf_wdata, q_count, stall);
    end
    idle();
  endtask

  task automatic test_fifo_full();
    idle();
    wb_valid = 1; wb_reg = 10; wb_data = 32'h10;
    mdu_valid = 1; mdu_reg = 11; mdu_data = 32'hA;
    cyc();
    total++;
    if (q_count !== 2'd1 || mdu_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_one got q=%0d rdy=%b want 1/1", q_count, mdu_ready);
    end
    mdu_reg = 12; mdu_data = 32'hB;
    cyc();
    total++;
    if (q_count !== 2'd2 || mdu_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_two got q=%0d rdy=%b want 2/0", q_count, mdu_ready);
    end
    mdu_reg = 13; mdu_data = 32'hC;
    cyc();
    total++;
    if (q_count !== 2'd2 || mdu_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_reject got q=%0d rdy=%b want 2/0", q_count, mdu_ready);
    end
    idle();
    cyc();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hA ||
        q_count !== 2'd1 || mdu_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop1 got we=%b a=%0d d=%h q=%0d rdy=%b want 1/11/a/1/1",
               rf_we, rf_waddr, rf_wdata, q_count, mdu_ready);
    end
    cyc();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hB || q_count !== 2'd0) begin
      bad++;
      $display("FAIL full_pop2 got we=%b a=%0d d=%h q=%0d want 1/12/b/0",
               rf_we, rf_waddr, rf_wdata, q_count);
    end
    cyc();
    total++;
    if (rf_we !== 1'b0 || q_count !== 2'd0) begin
      bad++;
      $display("FAIL full_empty got we=%b q=%0d want 0/0", rf_we, q_count);
    end
  endtask

  task automatic test_push_pop();
    logic [4:0]  er;
    logic [31:0] ed;
    idle();
    mdu_valid = 1; mdu_reg = 1; mdu_data = 32'd100;
    cyc();
    total++;
    if (q_count !== 2'd1 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL pp_first got q=%0d we=%b want 1/0", q_count, rf_we);
    end
    er = 5'd1; ed = 32'd100;
    for (int i = 0; i < 6; i++) begin
      mdu_valid = 1; mdu_reg = 5'(i + 2); mdu_data = 32'(200 + i);
      cyc();
      total++;
      if (q_count !== 2'd1 || rf_we !== 1'b1 || rf_waddr !== er || rf_wdata !== ed) begin
        bad++;
        $display("FAIL pp_iter[%0d] got q=%0d we=%b a=%0d d=%0d want 1/1/%0d/%0d",
                 i, q_count, rf_we, rf_waddr, rf_wdata, er, ed);
      end
      er = 5'(i + 2); ed = 32'(200 + i);
    end
    idle();
    cyc();
    total++;
    if (q_count !== 2'd0 || rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'd205) begin
      bad++;
      $display("FAIL pp_last got q=%0d we=%b a=%0d d=%0d want 0/1/7/205",
               q_count, rf_we, rf_waddr, rf_wdata);
    end
    mdu_valid = 1; mdu_reg = 0; mdu_data = 32'h55;
    cyc();
    idle();
    cyc();
    total++;
    if (rf_we !== 1'b0 || q_count !== 2'd0) begin
      bad++;
      $display("FAIL pp_x0 got we=%b q=%0d want 0/0", rf_we, q_count);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    issue_valid = 1; issue_reg = 9;
    cyc();
    issue_valid = 0; rs2 = 9;
    mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h99;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL sc_busy got stall=%b want 1", stall);
    end
    cyc();
    mdu_valid = 0;
    issue_valid = 1; issue_reg = 9;
    cyc();
    issue_valid = 0;
    #1;
    total++;
    if (stall !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      bad++;
      $display("FAIL sc_setwins got st=%b we=%b a=%0d want 1/1/9",
               stall, rf_we, rf_waddr);
    end
    cyc();
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL sc_hold got stall=%b want 1", stall);
    end
    mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h9A;
    cyc();
    mdu_valid = 0;
    cyc();
    #1;
    total++;
    if (stall !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9A) begin
      bad++;
      $display("FAIL sc_clear got st=%b a=%0d d=%h want 0/9/9a",
               stall, rf_waddr, rf_wdata);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wb_valid = 1; wb_reg = 4; wb_data = 32'h4;
    issue_valid = 1; issue_reg = 20;
    mdu_valid = 1; mdu_reg = 20; mdu_data = 32'h1;
    cyc();
    issue_valid = 0;
    mdu_reg = 21; mdu_data = 32'h2;
    cyc();
    mdu_valid = 0; rs1 = 20;
    #1;
    total++;
    if (q_count !== 2'd2 || stall !== 1'b1 || rf_we !== 1'b1) begin
      bad++;
      $display("FAIL rm_pre got q=%0d st=%b we=%b want 2/1/1", q_count, stall, rf_we);
    end
    #1;
    rst_n = 0;
    #1;
    total++;
    if (q_count !== 2'd0 || stall !== 1'b0 || mdu_ready !== 1'b1 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL rm_async got q=%0d st=%b rdy=%b we=%b want 0/0/1/0",
               q_count, stall, mdu_ready, rf_we);
    end
    idle();
    cyc();
    rst_n = 1;
    rs1 = 20; rs2 = 21;
    cyc();
    total++;
    if (q_count !== 2'd0 || stall !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL rm_after got q=%0d st=%b we=%b want 0/0/0", q_count, stall, rf_we);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wb();
    test_mdu_hazard();
    test_fifo_full();
    test_push_pop();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
